// File: rtl/rr_arbiter4.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter4
// Purpose  : Four-requester round-robin arbiter with optional hold timeout.
//            Produces a registered grant that is always all-zero or one-hot,
//            suitable for driving a one-hot to 2-bit index encoder directly.
//            Consecutive grants are always separated by one all-zero cycle.
// Ports    : clk     - system clock, rising edge
//            rst     - synchronous active-high reset
//            req     - [3:0] level-sensitive request lines
//            done    - release strobe from the current holder (GRANT only)
//            gnt     - [3:0] registered grant, all-zero or one-hot
//            busy    - high while a grant is held
//            timeout - one-cycle pulse when HOLD_MAX forces a release
// Params   : HOLD_MAX - max cycles a grant is held (0 = no timeout), 0..255
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter4 #(
    parameter int HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic       busy,
    output logic       timeout
);

    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_grant = 1'b1;

    // The hold counter is cleared on grant, so the last permitted cycle is
    // HOLD_MAX-1; with HOLD_MAX=0 the comparison is disabled entirely and the
    // counter is free to wrap.
    localparam logic       c_hold_en   = (HOLD_MAX > 0);
    localparam logic [7:0] c_hold_last = (HOLD_MAX > 0) ? 8'(HOLD_MAX - 1) : 8'd0;

    logic [0:0] r_state;
    logic [3:0] r_gnt;
    logic [1:0] r_ptr;
    logic [7:0] r_cnt;
    logic       r_timeout;

    logic [1:0] w_c1, w_c2, w_c3, w_c4;
    logic [1:0] w_idx;
    logic [3:0] w_gnt_next;
    logic       w_hold_expired;
    logic       w_release;

    // Candidates in round-robin order, starting just after the last grant.
    assign w_c1 = r_ptr + 2'd1;
    assign w_c2 = r_ptr + 2'd2;
    assign w_c3 = r_ptr + 2'd3;
    assign w_c4 = r_ptr;

    always_comb begin
        w_idx = w_c4;
        if (req[w_c1]) begin
            w_idx = w_c1;
        end else if (req[w_c2]) begin
            w_idx = w_c2;
        end else if (req[w_c3]) begin
            w_idx = w_c3;
        end
    end

    assign w_gnt_next     = 4'b0001 << w_idx;
    assign w_hold_expired = c_hold_en && (r_cnt == c_hold_last);
    assign w_release      = done | ~req[r_ptr] | w_hold_expired;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_st_idle;
            r_gnt     <= 4'b0000;
            r_ptr     <= 2'd3;
            r_cnt     <= 8'd0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            if (r_state == c_st_idle) begin
                if (|req) begin
                    r_gnt   <= w_gnt_next;
                    r_ptr   <= w_idx;
                    r_cnt   <= 8'd0;
                    r_state <= c_st_grant;
                end
            end else begin
                if (w_release) begin
                    r_gnt     <= 4'b0000;
                    r_state   <= c_st_idle;
                    // Pulse only when the timeout is the cause; done and a
                    // withdrawn request both take precedence over it.
                    r_timeout <= w_hold_expired & ~done & req[r_ptr];
                end else begin
                    r_cnt <= r_cnt + 8'd1;
                end
            end
        end
    end

    assign gnt     = r_gnt;
    assign busy    = (r_state == c_st_grant);
    assign timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter4.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_arbiter4
// Purpose  : Self-checking bench for rr_arbiter4. Two instances share the
//            stimulus: one with HOLD_MAX=3, one with the timeout disabled.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       done;

    logic [3:0] w_gnt3, w_gnt0;
    logic       w_busy3, w_busy0;
    logic       w_to3, w_to0;

    rr_arbiter4 #(.HOLD_MAX(3)) u_dut3 (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .gnt(w_gnt3), .busy(w_busy3), .timeout(w_to3)
    );

    rr_arbiter4 #(.HOLD_MAX(0)) u_dut0 (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .gnt(w_gnt0), .busy(w_busy0), .timeout(w_to0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: who holds the resource, who was served last, how many
    // cycles the grant has been visible, and whether a timeout just fired.
    int m_hold_max [2] = '{3, 0};
    int m_holder   [2];
    int m_last     [2];
    int m_shown    [2];
    bit m_to       [2];

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_holder[i] = -1;
                m_last[i]   = 3;
                m_shown[i]  = 0;
                m_to[i]     = 1'b0;
            end else if (m_holder[i] < 0) begin
                m_to[i] = 1'b0;
                if (req != 4'b0000) begin
                    for (int d = 1; d <= 4; d++) begin
                        int k;
                        k = (m_last[i] + d) % 4;
                        if (m_holder[i] < 0 && req[k]) begin
                            m_holder[i] = k;
                        end
                    end
                    m_last[i]  = m_holder[i];
                    m_shown[i] = 1;
                end
            end else begin
                bit expired;
                expired = (m_hold_max[i] > 0) && (m_shown[i] == m_hold_max[i]);
                if (done || !req[m_holder[i]] || expired) begin
                    m_to[i]     = !done && req[m_holder[i]] && expired;
                    m_holder[i] = -1;
                end else begin
                    m_to[i]    = 1'b0;
                    m_shown[i] = m_shown[i] + 1;
                end
            end
        end
    endtask

    function automatic logic [5:0] model_exp(input int i);
        logic [3:0] g;
        g = (m_holder[i] < 0) ? 4'b0000 : (4'b0001 << m_holder[i]);
        return {g, (m_holder[i] >= 0), m_to[i]};
    endfunction

    task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got gnt,busy,timeout=%b required %b", name, act, exp);
        end
    endtask

    task automatic chk_model();
        chk("model_h3", {w_gnt3, w_busy3, w_to3}, model_exp(0));
        chk("model_h0", {w_gnt0, w_busy0, w_to0}, model_exp(1));
    endtask

    // Advance one clock; model sees the same inputs the DUT samples, outputs
    // are compared 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       done;
        logic [3:0] gnt;
        logic       busy;
        logic       to;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic [3:0] q, input logic d,
                       input logic [3:0] g, input logic t);
        vec_t v;
        v.rst = r; v.req = q; v.done = d; v.gnt = g; v.busy = |g; v.to = t;
        tbl.push_back(v);
    endtask

    initial begin
        rst  = 1'b1;
        req  = 4'b0000;
        done = 1'b0;
        #1;

        // Expected values for the HOLD_MAX=3 instance, row by row.
        // Reset held two cycles with all requests active.
        add(1, 4'b1111, 0, 4'b0000, 0);
        add(1, 4'b1111, 0, 4'b0000, 0);
        add(0, 4'b1111, 0, 4'b0001, 0);
        // Rotation with one-cycle done pulses.
        add(0, 4'b1111, 1, 4'b0000, 0);
        add(0, 4'b1111, 0, 4'b0010, 0);
        add(0, 4'b1111, 1, 4'b0000, 0);
        add(0, 4'b1111, 0, 4'b0100, 0);
        add(0, 4'b1111, 1, 4'b0000, 0);
        add(0, 4'b1111, 0, 4'b1000, 0);
        add(0, 4'b1111, 1, 4'b0000, 0);
        add(0, 4'b1111, 0, 4'b0001, 0);
        add(0, 4'b1111, 1, 4'b0000, 0);
        add(0, 4'b1111, 0, 4'b0010, 0);
        // Skip and wrap from ptr=1.
        add(0, 4'b1111, 1, 4'b0000, 0);
        add(0, 4'b0001, 0, 4'b0001, 0);
        add(0, 4'b0001, 1, 4'b0000, 0);
        add(0, 4'b1001, 0, 4'b1000, 0);
        // Withdrawal, then done while idle.
        add(0, 4'b1001, 1, 4'b0000, 0);
        add(0, 4'b0100, 0, 4'b0100, 0);
        add(0, 4'b0000, 0, 4'b0000, 0);
        add(0, 4'b0000, 1, 4'b0000, 0);
        // Timeout after three visible cycles, then regrant.
        add(0, 4'b0010, 0, 4'b0010, 0);
        add(0, 4'b0010, 0, 4'b0010, 0);
        add(0, 4'b0010, 0, 4'b0010, 0);
        add(0, 4'b0010, 0, 4'b0000, 1);
        add(0, 4'b0010, 0, 4'b0010, 0);
        add(0, 4'b0010, 0, 4'b0010, 0);
        add(0, 4'b0010, 0, 4'b0010, 0);
        // done coincides with the timeout edge: done wins, no pulse.
        add(0, 4'b0010, 1, 4'b0000, 0);
        // Reset in the middle of a grant.
        add(0, 4'b1000, 0, 4'b1000, 0);
        add(1, 4'b1000, 0, 4'b0000, 0);
        add(0, 4'b1111, 0, 4'b0001, 0);
        // Other request bits changing during a grant are ignored.
        add(0, 4'b1101, 0, 4'b0001, 0);
        add(0, 4'b0001, 0, 4'b0001, 0);
        add(0, 4'b0001, 0, 4'b0000, 1);
        add(1, 4'b0000, 0, 4'b0000, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            rst  = tbl[i].rst;
            req  = tbl[i].req;
            done = tbl[i].done;
            step();
            chk($sformatf("vec%0d", i), {w_gnt3, w_busy3, w_to3},
                {tbl[i].gnt, tbl[i].busy, tbl[i].to});
            chk_model();
        end

        // Long hold: the HOLD_MAX=0 instance must keep the grant across a
        // counter wrap, while the other instance keeps timing out.
        rst  = 1'b0;
        req  = 4'b0100;
        done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            step();
            chk_model();
        end
        chk("nohold_long", {w_gnt0, w_busy0, w_to0}, {4'b0100, 1'b1, 1'b0});

        // Randomized traffic with sticky requests so holds can run long.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 3) == 0) begin
                req = 4'($urandom_range(0, 15));
            end
            done = ($urandom_range(0, 4) == 0);
            step();
            chk_model();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rr_arbiter4.md
Name: rr_arbiter4

Overview:
- Four-requester round-robin arbiter.
- Produces the registered one-hot grant vector that drives the 4-to-2 encoder directly downstream.
- The encoder turns gnt into a 2-bit requester index.
- Guarantees gnt is always all-zero or exactly one-hot. This is required because the encoder only decodes the four one-hot codes.

Parameters:
- HOLD_MAX, 8: maximum cycles a grant may be held before forced release; 0 disables the timeout. Legal range 0..255.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request lines; bit k = requester k wants the resource; level-sensitive.
- done  input  1  holder's release strobe; sampled only in GRANT.
- gnt  output  4  registered grant; all-zero or one-hot; feeds the encoder input.
- busy  output  1  high while in GRANT (gnt nonzero).
- timeout  output  1  one-cycle pulse when a grant is force-released by HOLD_MAX.

Behaviour:
- Reset (rst=1 at a clock edge) produces the following, regardless of state, including mid-grant:
  - state=IDLE, gnt=4'b0000, busy=0, timeout=0, hold counter=0.
  - Last-grant pointer ptr=3, so requester 0 has highest priority first.
- States: IDLE, GRANT. Two-bit or one-bit encoding; implementer's choice.
- IDLE, req==0: stay; gnt=0.
- IDLE, req!=0: next edge performs all of the following:
  - Scans k = ptr+1, ptr+2, ... (mod 4) and grants the first k with req[k]=1.
  - Sets gnt=one-hot(k), ptr=k, counter=0, state=GRANT.
  - Latency req->gnt = 1 cycle.
- GRANT: gnt held constant and counter increments each cycle. Release conditions, evaluated each edge in priority order:
  1. done=1.
  2. req[ptr]=0 (holder withdrew).
  3. HOLD_MAX>0 and counter==HOLD_MAX-1; timeout=1 for that one cycle.
- On release: next edge gives gnt=0, busy=0, state=IDLE. A mandatory single idle cycle separates consecutive grants, so the encoder never sees a grant-to-grant transition.
- done asserted in IDLE: ignored.
- Simultaneous release conditions: exactly one release occurs. timeout pulses only if done=0 and req[ptr]=1 at that edge.
- Changes to req bits other than ptr during GRANT are ignored until the next IDLE arbitration.
- Fairness: a continuously requesting k waits at most 3 other grants.
- Counter width is 8 bits; no overflow is possible because the release occurs at HOLD_MAX-1.
- With HOLD_MAX=0 the counter may free-run. It must not affect behaviour.
- timeout is a registered pulse: high exactly one cycle, coincident with gnt going 0.

Test Plan:
- Reset: assert rst 2 cycles with req=4'b1111 -> gnt=0000, busy=0, timeout=0 throughout. After release, the first grant is 0001 one cycle later.
- Rotation: req=4'b1111 held; each grant is released by a one-cycle done pulse. Grant sequence 0001,0000,0010,0000,0100,0000,1000,0000,0001, with each 0000 lasting exactly one cycle.
- Skip and wrap: ptr=1 (last grant 0010); req=4'b0001 -> next grant 0001, not 0010. Then req=4'b1001 after release -> grant 1000.
- Withdrawal: grant 0100 active; drop req[2] -> gnt=0000 the next edge; timeout stays 0.
- Timeout with HOLD_MAX=3: req=0010 held, done=0 -> gnt=0010 for exactly 3 cycles. timeout=1 together with gnt=0000 for 1 cycle. Regrant 0010 on the following cycle.
- Reset mid-grant: gnt=1000 active; assert rst for one cycle -> gnt=0000 on that edge and ptr=3. Next grant with req=1111 is 0001.
